md_sequencer: RTL and testbench
===============================

# md_sequencer

Multi-cycle sequencer for the HI/LO multiply/divide resource in the EX stage. It accepts the decoded MD function (mthi/mtlo/mult/multu/div/divu) together with operands, and runs an iterative shift-add multiply or restoring divide. It owns the HI/LO architectural registers and raises `md_busy` so the stall detector can hold mfhi/mflo and any following MD instruction in ID until the result is committed.

## Interface
- No parameters; datapath fixed at 32 bits.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `md_start` in 1: EX-stage instruction carries an MD function this cycle.
- `md_func` in 3: 0 none, 1 mthi, 2 mtlo, 3 mul, 4 div; 5–7 treated as 0.
- `md_sign` in 1: 1 = signed (mult/div), 0 = unsigned (multu/divu).
- `md_a` in 32: rs operand; dividend / multiplicand / mthi-mtlo source.
- `md_b` in 32: rt operand; divisor / multiplier.
- `md_flush` in 1: abort any in-flight operation.
- `md_busy` out 1: registered; high while state ≠ IDLE.
- `md_done` out 1: registered one-cycle pulse after HI/LO commit of mul/div.
- `hi` out 32: HI register.
- `lo` out 32: LO register.

## Operation
- Accept condition: `md_start && !md_flush && state==IDLE`. `md_start` in any other state is ignored. Stall detect guarantees this does not happen, and the bench checks it.
- States: IDLE, MUL, DIV, FIX.
- IDLE transitions:
  - func 1: hi←md_a. func 2: lo←md_a. Both complete in one cycle, with no busy and no done.
  - func 3: latch |a|,|b| (magnitudes only if `md_sign`), clear the 64-bit accumulator, counter←0, record result sign = a[31]^b[31] (signed only), go to MUL.
  - func 4 with md_b==0: no iteration. At the accept edge hi←md_a, lo←32'hFFFF_FFFF, and done pulses next cycle.
  - func 4 otherwise: latch magnitudes. Record quotient sign = a[31]^b[31] and remainder sign = a[31] (signed only). Go to DIV.
- MUL: one shift-add step per cycle, LSB-first multiplier. Counter increments and wraps 31→0, at which point go to FIX.
- DIV: one restoring step per cycle. Remainder shifted left by 1 with the next dividend bit, trial subtract, quotient bit = no-borrow. On counter 31→0 go to FIX.
- FIX: apply two's-complement negation per the recorded signs. MUL negates the 64-bit product; DIV negates quotient and remainder separately.
  - MUL commits hi←prod[63:32], lo←prod[31:0].
  - DIV commits lo←quotient, hi←remainder.
  - Go to IDLE and set done for the next cycle.
- Arithmetic: magnitude of 0x8000_0000 is 0x8000_0000 treated as unsigned. This makes signed 0x8000_0000 / 0xFFFF_FFFF yield lo=0x8000_0000, hi=0 (wrap, no trap).
- `md_flush` in MUL/DIV/FIX: go to IDLE at the next edge. HI/LO are unchanged and no done is produced. Flush has priority over FIX commit.
- Reset (asynchronous, any state): state=IDLE, counter=0, hi=0, lo=0, md_busy=0, md_done=0. Internal operand registers are reset to 0.

## Timing
- mthi/mtlo: write visible on `hi`/`lo` the cycle after accept. Latency 1, throughput 1/cycle.
- mul/div: accept at edge E0. MUL/DIV iterate at E1..E32. FIX commits at E33.
  - `md_busy` high for the 33 cycles after E0.
  - `md_done` high in the cycle after E33, and hi/lo are valid then.
  - A new accept is possible at E33+1.
- Divide-by-zero: commit at E0, `md_done` high in the cycle after E0, `md_busy` never asserted.
- `md_done` never coincides with `md_busy`.

## Configuration
- `MD_FAST_MUL_EN` defined: mul (func 3) uses a single-cycle combinational signed/unsigned 32×32 multiplier.
  - hi/lo commit at the accept edge and `md_done` pulses the next cycle.
  - The MUL state is unreachable and `md_busy` is never raised for mul.
  - Divide is unchanged.
- Undefined: the iterative 33-cycle multiply described above.

## Test plan
- Reset mid-DIV (at ~E10, reset low): hi=lo=0, md_busy=0 immediately. After release, IDLE accepts a new op.
- Signed mult a=0xFFFF_FFFD (−3), b=7: md_done at E34; hi=0xFFFF_FFFF, lo=0xFFFF_FFEB. Unsigned multu 0xFFFF_FFFF×0xFFFF_FFFF: hi=0xFFFF_FFFE, lo=0x0000_0001.
- Signed div −7/2: lo=0xFFFF_FFFD, hi=0xFFFF_FFFF. divu 100/7: lo=14, hi=2. Signed 0x8000_0000/0xFFFF_FFFF: lo=0x8000_0000, hi=0.
- div by zero, a=0x1234: next cycle hi=0x1234, lo=0xFFFF_FFFF, md_done=1, md_busy=0 throughout.
- mthi 0xAAAA then mtlo 0x5555 back-to-back: hi=0xAAAA, lo=0x5555 one cycle after each. md_start during busy (func 2) leaves lo unchanged.
- md_flush at E20 of mult: md_busy drops next cycle, no md_done, hi/lo retain prior values. With `MD_FAST_MUL_EN`: mult 6×7 gives lo=42 and md_done the next cycle, with no busy.

Source files
------------

// File: rtl/md_sequencer.sv
// md_sequencer: multi-cycle HI/LO multiply/divide unit for the EX stage.
// Runs an iterative shift-add multiply or restoring divide and owns HI/LO.
// md_busy lets the stall detector hold mfhi/mflo and later MD instructions in ID.
//
// Ports:
//   clk       in   clock, rising edge
//   reset     in   asynchronous active-low reset
//   md_start  in   MD function present in EX this cycle
//   md_func   in   0 none, 1 mthi, 2 mtlo, 3 mul, 4 div (5-7 = none)
//   md_sign   in   1 signed, 0 unsigned
//   md_a      in   rs operand (dividend / multiplicand / mthi-mtlo source)
//   md_b      in   rt operand (divisor / multiplier)
//   md_flush  in   abort in-flight operation
//   md_busy   out  high while not IDLE
//   md_done   out  one-cycle pulse after a mul/div commit
//   hi, lo    out  architectural HI/LO registers
//
// Build option: define MD_FAST_MUL_EN for a single-cycle combinational multiply.
module md_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        md_start,
    input  logic [2:0]  md_func,
    input  logic        md_sign,
    input  logic [31:0] md_a,
    input  logic [31:0] md_b,
    input  logic        md_flush,
    output logic        md_busy,
    output logic        md_done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] FIX  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    // Mul: running product. Div: {remainder, quotient}.
    logic [63:0] acc_q, acc_d;
    logic        neg_q, neg_d;      // product / quotient sign
    logic        rneg_q, rneg_d;    // remainder sign
    logic        is_mul_q, is_mul_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic        done_q, done_d;

    logic [31:0] a_mag, b_mag;
    logic [63:0] mul_add, prod_fix;
    logic [32:0] rem_shift;
    logic [33:0] div_diff;
    logic        q_bit;
    logic [31:0] rem_next, quo_fix, rem_fix;

    // Magnitude of 0x8000_0000 wraps to itself and is then used as unsigned.
    assign a_mag = (md_sign && md_a[31]) ? (~md_a + 32'd1) : md_a;
    assign b_mag = (md_sign && md_b[31]) ? (~md_b + 32'd1) : md_b;

    assign mul_add   = b_q[cnt_q] ? ({32'd0, a_q} << cnt_q) : 64'd0;

    // Restoring step: bring in dividend bits MSB first, keep the trial result on no-borrow.
    assign rem_shift = {acc_q[63:32], a_q[5'd31 - cnt_q]};
    assign div_diff  = {1'b0, rem_shift} - {2'b00, b_q};
    assign q_bit     = ~div_diff[33];
    assign rem_next  = q_bit ? div_diff[31:0] : rem_shift[31:0];

    assign prod_fix = neg_q  ? (~acc_q + 64'd1)         : acc_q;
    assign quo_fix  = neg_q  ? (~acc_q[31:0] + 32'd1)   : acc_q[31:0];
    assign rem_fix  = rneg_q ? (~acc_q[63:32] + 32'd1)  : acc_q[63:32];

`ifdef MD_FAST_MUL_EN
    logic [63:0] fast_a, fast_b, fast_prod;
    // Low 64 bits of the product of sign/zero-extended operands are exact for both modes.
    assign fast_a    = md_sign ? {{32{md_a[31]}}, md_a} : {32'd0, md_a};
    assign fast_b    = md_sign ? {{32{md_b[31]}}, md_b} : {32'd0, md_b};
    assign fast_prod = fast_a * fast_b;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        is_mul_d = is_mul_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (md_start && !md_flush) begin
                    case (md_func)
                        3'd1: hi_d = md_a;
                        3'd2: lo_d = md_a;
                        3'd3: begin
`ifdef MD_FAST_MUL_EN
                            hi_d   = fast_prod[63:32];
                            lo_d   = fast_prod[31:0];
                            done_d = 1'b1;
`else
                            a_d      = a_mag;
                            b_d      = b_mag;
                            acc_d    = 64'd0;
                            cnt_d    = 5'd0;
                            neg_d    = md_sign & (md_a[31] ^ md_b[31]);
                            rneg_d   = 1'b0;
                            is_mul_d = 1'b1;
                            state_d  = MUL;
`endif
                        end
                        3'd4: begin
                            if (md_b == 32'd0) begin
                                hi_d   = md_a;
                                lo_d   = 32'hFFFF_FFFF;
                                done_d = 1'b1;
                            end else begin
                                a_d      = a_mag;
                                b_d      = b_mag;
                                acc_d    = 64'd0;
                                cnt_d    = 5'd0;
                                neg_d    = md_sign & (md_a[31] ^ md_b[31]);
                                rneg_d   = md_sign & md_a[31];
                                is_mul_d = 1'b0;
                                state_d  = DIV;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            MUL: begin
                if (md_flush) begin
                    state_d = IDLE;
                end else begin
                    acc_d = acc_q + mul_add;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) state_d = FIX;
                end
            end
            DIV: begin
                if (md_flush) begin
                    state_d = IDLE;
                end else begin
                    acc_d = {rem_next, acc_q[30:0], q_bit};
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!md_flush) begin
                    if (is_mul_q) begin
                        hi_d = prod_fix[63:32];
                        lo_d = prod_fix[31:0];
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end
                    done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= 5'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            acc_q    <= 64'd0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            is_mul_q <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            is_mul_q <= is_mul_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign md_busy = (state_q != IDLE);
    assign md_done = done_q;
    assign hi      = hi_q;
    assign lo      = lo_q;

endmodule

// File: tb/tb_md_sequencer.sv
module tb_md_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        md_start = 1'b0;
    logic [2:0]  md_func = 3'd0;
    logic        md_sign = 1'b0;
    logic [31:0] md_a = 32'd0;
    logic [31:0] md_b = 32'd0;
    logic        md_flush = 1'b0;
    logic        md_busy, md_done;
    logic [31:0] hi, lo;

`ifdef MD_FAST_MUL_EN
    localparam int MUL_LAT = 1;
    localparam logic [2:0] FLUSH_FUNC = 3'd4;
`else
    localparam int MUL_LAT = 34;
    localparam logic [2:0] FLUSH_FUNC = 3'd3;
`endif
    localparam int DIV_LAT = 34;

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] exp_q[$];

    md_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .md_start (md_start),
        .md_func  (md_func),
        .md_sign  (md_sign),
        .md_a     (md_a),
        .md_b     (md_b),
        .md_flush (md_flush),
        .md_busy  (md_busy),
        .md_done  (md_done),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: independent 64-bit integer arithmetic, returns {hi, lo}.
    function automatic logic [63:0] model(input logic [2:0] f, input logic s,
                                          input logic [31:0] a, input logic [31:0] b);
        longint sa, sbv, q, r, p;
        sa  = s ? longint'($signed(a)) : longint'(a);
        sbv = s ? longint'($signed(b)) : longint'(b);
        if (f == 3'd3) begin
            p = sa * sbv;
            return p;
        end
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sbv;
        r = sa % sbv;
        return {r[31:0], q[31:0]};
    endfunction

    // Scoreboard: every md_done pops one expected {hi, lo}.
    always @(negedge clk) begin
        if (reset && md_done) begin
            check_eq("done_busy", {63'd0, md_busy}, 64'd0);
            if (exp_q.size() == 0) begin
                check_eq("unexp_done", {63'd0, md_done}, 64'd0);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check_eq("hi", {32'd0, hi}, {32'd0, e[63:32]});
                check_eq("lo", {32'd0, lo}, {32'd0, e[31:0]});
            end
        end
    end

    // Issue one mul/div, wait for done, check latency. poke: mtlo during busy is ignored.
    task automatic run_op(input string tag, input logic [2:0] f, input logic s,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int lat, input bit poke);
        int n;
        bit seen;
        logic [31:0] lo_prev;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        md_start = 1'b1; md_func = f; md_sign = s; md_a = a; md_b = b;
        @(posedge clk); #1;
        md_start = 1'b0; md_func = 3'd0;
        lo_prev = lo;
        n = 0;
        seen = 1'b0;
        while (!seen && n <= 100) begin
            @(negedge clk);
            n++;
            if (n == 1) check_eq({tag, "_busy"}, {63'd0, md_busy}, {63'd0, (lat > 1)});
            if (poke && n == 5) begin
                md_start = 1'b1; md_func = 3'd2; md_a = 32'hDEAD_BEEF;
            end
            if (poke && n == 6) begin
                md_start = 1'b0; md_func = 3'd0;
                check_eq({tag, "_poke_lo"}, {32'd0, lo}, {32'd0, lo_prev});
            end
            if (md_done) seen = 1'b1;
        end
        check_eq({tag, "_lat"}, 64'(n), 64'(lat));
    endtask

    task automatic flush_op(input logic [2:0] f);
        logic [31:0] hp, lp;
        bit done_seen;
        hp = hi;
        lp = lo;
        done_seen = 1'b0;
        @(posedge clk); #1;
        md_start = 1'b1; md_func = f; md_sign = 1'b0; md_a = 32'd12345; md_b = 32'd67;
        @(posedge clk); #1;
        md_start = 1'b0; md_func = 3'd0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (n == 19) check_eq("flush_busy_pre", {63'd0, md_busy}, 64'd1);
            if (n == 20) md_flush = 1'b1;
            if (n == 21) begin
                md_flush = 1'b0;
                check_eq("flush_busy_post", {63'd0, md_busy}, 64'd0);
            end
            if (md_done) done_seen = 1'b1;
        end
        check_eq("flush_no_done", {63'd0, done_seen}, 64'd0);
        check_eq("flush_hi", {32'd0, hi}, {32'd0, hp});
        check_eq("flush_lo", {32'd0, lo}, {32'd0, lp});
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_eq("rst_hi", {32'd0, hi}, 64'd0);
        check_eq("rst_lo", {32'd0, lo}, 64'd0);
        check_eq("rst_busy", {63'd0, md_busy}, 64'd0);
        check_eq("rst_done", {63'd0, md_done}, 64'd0);
        reset = 1'b1;

        // mthi then mtlo back-to-back
        @(posedge clk); #1;
        md_start = 1'b1; md_func = 3'd1; md_a = 32'h0000_AAAA;
        @(posedge clk); #1;
        md_func = 3'd2; md_a = 32'h0000_5555;
        @(negedge clk);
        check_eq("mthi_hi", {32'd0, hi}, 64'h0000_AAAA);
        check_eq("mthi_busy", {63'd0, md_busy}, 64'd0);
        @(posedge clk); #1;
        md_start = 1'b0; md_func = 3'd0;
        @(negedge clk);
        check_eq("mtlo_lo", {32'd0, lo}, 64'h0000_5555);
        check_eq("mtlo_hi", {32'd0, hi}, 64'h0000_AAAA);
        check_eq("mtlo_done", {63'd0, md_done}, 64'd0);

        run_op("mult_neg", 3'd3, 1'b1, 32'hFFFF_FFFD, 32'd7,
               64'hFFFF_FFFF_FFFF_FFEB, MUL_LAT, 1'b0);
        run_op("multu_max", 3'd3, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               64'hFFFF_FFFE_0000_0001, MUL_LAT, 1'b0);
        run_op("mult_6x7", 3'd3, 1'b1, 32'd6, 32'd7, 64'd42, MUL_LAT, 1'b0);
        run_op("div_neg", 3'd4, 1'b1, 32'hFFFF_FFF9, 32'd2,
               64'hFFFF_FFFF_FFFF_FFFD, DIV_LAT, 1'b0);
        run_op("divu_100_7", 3'd4, 1'b0, 32'd100, 32'd7,
               64'h0000_0002_0000_000E, DIV_LAT, 1'b1);
        run_op("div_ovf", 3'd4, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
               64'h0000_0000_8000_0000, DIV_LAT, 1'b0);
        run_op("div_zero", 3'd4, 1'b1, 32'h0000_1234, 32'd0,
               64'h0000_1234_FFFF_FFFF, 1, 1'b0);

        for (int i = 0; i < 6; i++) begin
            logic [2:0] f;
            logic s;
            logic [31:0] a, b;
            f = (i % 2 == 0) ? 3'd3 : 3'd4;
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom;
            if (i >= 4) b = b >> 24;
            if (f == 3'd4 && b == 32'd0) b = 32'd3;
            run_op("rand", f, s, a, b, model(f, s, a, b),
                   (f == 3'd3) ? MUL_LAT : DIV_LAT, 1'b0);
        end

        flush_op(FLUSH_FUNC);

        // Asynchronous reset in the middle of a divide
        @(posedge clk); #1;
        md_start = 1'b1; md_func = 3'd4; md_sign = 1'b0; md_a = 32'd999; md_b = 32'd5;
        @(posedge clk); #1;
        md_start = 1'b0; md_func = 3'd0;
        repeat (10) @(negedge clk);
        check_eq("pre_rst_busy", {63'd0, md_busy}, 64'd1);
        reset = 1'b0;
        #1;
        check_eq("mid_rst_hi", {32'd0, hi}, 64'd0);
        check_eq("mid_rst_lo", {32'd0, lo}, 64'd0);
        check_eq("mid_rst_busy", {63'd0, md_busy}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        run_op("post_rst_divu", 3'd4, 1'b0, 32'd1000, 32'd9,
               model(3'd4, 1'b0, 32'd1000, 32'd9), DIV_LAT, 1'b0);

        repeat (3) @(negedge clk);
        check_eq("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
